// File: rtl/row_pkt_pkg.sv
// Shared types for the 5-pixel row packet link.
// Packet kinds, decoder states and the run record.
package row_pkt_pkg;
  localparam int PKT_W  = 16;
  localparam int PIX_W  = 3;
  localparam int NPIX   = 5;
  localparam int TS_W   = 15;
  localparam int TIME_W = 45;
  localparam int RUN_W  = 16;
  localparam int REC_PIX_W = PIX_W * NPIX;
  localparam logic [PKT_W-1:0] WRAP_MARK = 16'h8000;

  typedef enum logic [1:0] {
    PK_RAW,
    PK_TS,
    PK_WRAP
  } pkt_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAW,
    ST_REPEAT
  } dec_state_e;

  typedef struct packed {
    logic [REC_PIX_W-1:0] pixels;
    logic [TIME_W-1:0]    start;
    logic [RUN_W-1:0]     run;
  } run_rec_t;

  function automatic pkt_kind_e pkt_kind(
    input logic [PKT_W-1:0] d
  );
    pkt_kind_e k;
    if (d == WRAP_MARK)   k = PK_WRAP;
    else if (d[PKT_W-1]) k = PK_TS;
    else                 k = PK_RAW;
    return k;
  endfunction

  function automatic logic [RUN_W-1:0] sat_run(
    input logic [TIME_W-1:0] diff
  );
    logic [RUN_W-1:0] r;
    if (|diff[TIME_W-1:RUN_W]) r = '1;
    else                       r = diff[RUN_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/row_rec_fifo.sv
// Small synchronous record FIFO with valid/ready drain.
// Head reads as zero while empty.
module row_rec_fifo
  import row_pkt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  run_rec_t push_rec,
  input  logic     pop,
  output logic     valid,
  output run_rec_t head,
  output logic     full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  run_rec_t        mem_q [DEPTH];
  run_rec_t        mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  assign valid = cnt_q != '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign head  = valid ? mem_q[rd_q] : '0;

  always_comb begin
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_rec;
      wr_d = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/row_decoder_5p.sv
// Row packet link receiver: rebuilds the time base and
// turns raw/timestamp/wrap packets into run records.
module row_decoder_5p
  import row_pkt_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  input  logic [15:0] pkt_data,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [14:0] rec_pixels,
  output logic [44:0] rec_time,
  output logic [15:0] rec_run,
  output logic        err_ts,
  output logic        err_wrap,
  output logic        overflow
);
  localparam logic [TIME_W-1:0] TIME_RST =
    TIME_W'(0) - TIME_W'(LAT);
  localparam int UP_W = TIME_W - TS_W;

  dec_state_e           state_q, state_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [TIME_W-1:0]    start_q, start_d;
  logic [REC_PIX_W-1:0] pix_q, pix_d;
  logic                 err_ts_q, err_ts_d;
  logic                 err_wrap_q, err_wrap_d;
  logic                 overflow_q, overflow_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 ts_miss;
  logic [UP_W-1:0]      upper;
  run_rec_t             push_rec;
  run_rec_t             head;

  assign upper   = time_q[TIME_W-1:TS_W];
  assign ts_miss = pkt_data[TS_W-1:0] != time_q[TS_W-1:0];
  assign pop     = rec_valid & rec_ready;

  always_comb begin
    time_d     = time_q + TIME_W'(1);
    state_d    = state_q;
    start_d    = start_q;
    pix_d      = pix_q;
    err_ts_d   = 1'b0;
    err_wrap_d = 1'b0;
    push       = 1'b0;
    push_rec   = '{pixels: pix_q, start: start_q,
                   run: sat_run(time_q - start_q)};
    if (pkt_valid) begin
      unique case (pkt_kind(pkt_data))
        PK_RAW: begin
          push    = state_q != ST_IDLE;
          pix_d   = pkt_data[REC_PIX_W-1:0];
          start_d = time_q;
          state_d = ST_RAW;
        end
        PK_TS: begin
          if (state_q != ST_IDLE) begin
            err_ts_d = ts_miss | (state_q == ST_REPEAT);
            if (ts_miss)
              time_d = {upper, pkt_data[TS_W-1:0]};
            state_d = ST_REPEAT;
          end
        end
        PK_WRAP: begin
          // early marker owes the upper bits the missed carry
          if (|time_q[TS_W-1:0]) begin
            err_wrap_d = 1'b1;
            time_d = {upper + UP_W'(time_q[TS_W-1]),
                      {TS_W{1'b0}}};
          end
        end
        default: ;
      endcase
    end
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= TIME_RST;
      state_q    <= ST_IDLE;
      start_q    <= '0;
      pix_q      <= '0;
      err_ts_q   <= 1'b0;
      err_wrap_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      state_q    <= state_d;
      start_q    <= start_d;
      pix_q      <= pix_d;
      err_ts_q   <= err_ts_d;
      err_wrap_q <= err_wrap_d;
      overflow_q <= overflow_d;
    end
  end

  row_rec_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_rec(push_rec),
    .pop     (pop),
    .valid   (rec_valid),
    .head    (head),
    .full    (fifo_full)
  );

  assign rec_pixels = head.pixels;
  assign rec_time   = head.start;
  assign rec_run    = head.run;
  assign err_ts     = err_ts_q;
  assign err_wrap   = err_wrap_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_row_decoder_5p.sv
// Bench for row_decoder_5p: directed link scenarios plus
// random packet traffic against a queue-based reference.
module tb_row_decoder_5p;
  localparam int LAT = 1;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic [15:0] pkt_data;
  logic        rec_valid;
  logic        rec_ready;
  logic [14:0] rec_pixels;
  logic [44:0] rec_time;
  logic [15:0] rec_run;
  logic        err_ts;
  logic        err_wrap;
  logic        overflow;

  row_decoder_5p #(.LAT(LAT), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_pixels(rec_pixels),
    .rec_time  (rec_time),
    .rec_run   (rec_run),
    .err_ts    (err_ts),
    .err_wrap  (err_wrap),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] p;
    logic [44:0] t;
    logic [15:0] r;
  } mrec_t;

  int n_chk = 0;
  int n_err = 0;

  mrec_t       q[$];
  logic [44:0] m_time;
  logic [44:0] m_start;
  logic [14:0] m_pix;
  bit          m_have;
  bit          m_rep;
  bit          m_ovf;
  bit          m_ets;
  bit          m_ewrap;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_push(input mrec_t rr);
    if (q.size() < 2) q.push_back(rr);
    else m_ovf = 1'b1;
  endtask

  // one clock of the link, at the level of the rules
  task automatic step(input bit r, input bit v,
                      input logic [15:0] d, input bit rdy);
    logic [44:0] nt;
    logic [44:0] diff;
    logic [44:0] up;
    mrec_t       rr;
    if (r) begin
      m_time = 45'd0 - 45'(LAT);
      m_have = 0; m_rep = 0; m_pix = '0; m_start = '0;
      m_ovf = 0; m_ets = 0; m_ewrap = 0;
      q.delete();
      return;
    end
    if (q.size() > 0 && rdy) void'(q.pop_front());
    m_ets = 0;
    m_ewrap = 0;
    nt = m_time + 45'd1;
    if (v) begin
      if (d[15] == 1'b0) begin
        if (m_have) begin
          diff = m_time - m_start;
          rr.p = m_pix;
          rr.t = m_start;
          rr.r = (diff > 45'd65535) ? 16'hFFFF : diff[15:0];
          m_push(rr);
        end
        m_pix = d[14:0];
        m_start = m_time;
        m_have = 1;
        m_rep = 0;
      end else if (d == 16'h8000) begin
        if (m_time % 32768 != 0) begin
          m_ewrap = 1;
          up = m_time / 32768;
          if (m_time % 32768 >= 16384) up = up + 1;
          nt = up * 32768;
        end
      end else if (m_have) begin
        if (m_rep || (m_time % 32768) != 45'(d[14:0]))
          m_ets = 1;
        if ((m_time % 32768) != 45'(d[14:0]))
          nt = (m_time / 32768) * 32768 + 45'(d[14:0]);
        m_rep = 1;
      end
    end
    m_time = nt;
  endtask

  task automatic cmp_model();
    mrec_t h;
    h.p = '0; h.t = '0; h.r = '0;
    if (q.size() > 0) h = q[0];
    check("valid", rec_valid, q.size() > 0);
    check("pixels", rec_pixels, h.p);
    check("time", rec_time, h.t);
    check("run", rec_run, h.r);
    check("err_ts", err_ts, m_ets);
    check("err_wrap", err_wrap, m_ewrap);
    check("overflow", overflow, m_ovf);
  endtask

  // entered and left at a falling edge
  task automatic cyc(input bit r, input bit v,
                     input logic [15:0] d);
    rst = r;
    pkt_valid = v;
    pkt_data = d;
    @(posedge clk);
    step(r, v, d, rec_ready);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle_to(input logic [44:0] t);
    int n;
    n = 0;
    while (m_time != t && n < 200) begin
      cyc(0, 0, 16'h0);
      n++;
    end
    if (m_time != t) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_to got %0h exp %0h", m_time, t);
    end
  endtask

  initial begin
    logic [15:0] d;
    int          k;
    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = '0;
    rec_ready = 1'b1;
    @(negedge clk);
    cyc(1, 0, 16'h0);
    cyc(1, 0, 16'h0);
    check("rst_valid", rec_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pix", rec_pixels, 0);

    idle_to(45'd5);
    cyc(0, 1, 16'h1234);
    idle_to(45'd9);
    cyc(0, 1, 16'h0ABC);
    check("r1_valid", rec_valid, 1);
    check("r1_pix", rec_pixels, 15'h1234);
    check("r1_time", rec_time, 45'd5);
    check("r1_run", rec_run, 16'd4);

    cyc(0, 1, 16'h0111);
    cyc(0, 1, 16'h800B);
    check("ts_ok", err_ts, 0);
    idle_to(45'd20);
    cyc(0, 1, 16'h0222);
    check("r2_pix", rec_pixels, 15'h0111);
    check("r2_time", rec_time, 45'd10);
    check("r2_run", rec_run, 16'd10);

    cyc(0, 1, 16'h8010);
    check("ts_bad", err_ts, 1);
    repeat (3) cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h0333);
    cyc(0, 0, 16'h0);

    cyc(0, 1, 16'h7FFD);
    cyc(0, 1, 16'h0444);
    cyc(0, 1, 16'hFFFD);
    cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h8000);
    check("wrap_early", err_wrap, 1);
    cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h8000);
    check("wrap_late", err_wrap, 1);
    cyc(0, 1, 16'h8000);
    check("wrap_ok", err_wrap, 0);

    repeat (3) cyc(0, 0, 16'h0);
    rec_ready = 1'b0;
    cyc(0, 1, 16'h0A01);
    cyc(0, 1, 16'h0A02);
    cyc(0, 1, 16'h0A03);
    cyc(0, 1, 16'h0A04);
    check("bp_ovf", overflow, 1);
    check("bp_valid", rec_valid, 1);
    rec_ready = 1'b1;
    repeat (3) cyc(0, 0, 16'h0);
    check("drain_valid", rec_valid, 0);
    check("drain_ovf", overflow, 1);

    cyc(0, 1, 16'h1111);
    repeat (70000) cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h2222);
    check("sat_run", rec_run, 16'hFFFF);

    cyc(0, 1, {1'b1, m_time[14:0] ^ 15'h0001});
    cyc(1, 0, 16'h0);
    check("mid_rst_valid", rec_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ets", err_ts, 0);
    cyc(0, 1, 16'h0555);
    cyc(0, 1, 16'h0666);
    check("post_rst_pix", rec_pixels, 15'h0555);

    for (int i = 0; i < 4000; i++) begin
      rec_ready = $urandom_range(0, 3) != 0;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 499) == 0) begin
        cyc(1, 0, 16'h0);
      end else if (k <= 4) begin
        d = {1'b0, 15'($urandom)};
        cyc(0, 1, d);
      end else if (k == 5) begin
        if (m_time[14:0] == 15'd0) d = 16'h8000;
        else d = {1'b1, m_time[14:0]};
        cyc(0, 1, d);
      end else if (k == 6) begin
        d = {1'b1, 15'($urandom_range(1, 32767))};
        cyc(0, 1, d);
      end else if (k == 7) begin
        cyc(0, 1, 16'h8000);
      end else begin
        cyc(0, 0, 16'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/row_decoder_5p.md
Name: row_decoder_5p

Overview:
- Receive end of the 5-pixel row packet link. Consumes the 16-bit packet stream (raw / timestamp / wrap-marker) produced by the row encoder.
- Rebuilds a local 45-bit time base in lockstep with the encoder's global timer and checks it against received timestamps and wrap markers.
- Emits one run record per distinct 5-pixel pattern: pixels, 45-bit start time, run length. Records go to a downstream consumer through a 2-entry output FIFO with valid/ready.

Parameters:
- LAT, 1: link latency in clocks from encoder timer sample to packet at pkt_data. The local time counter resets to (2^45 - LAT) mod 2^45.
- FIFO_DEPTH, 2: output record FIFO depth. Fixed at 2 for this block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  pkt_data holds a packet this cycle; at most one packet per clk, no backpressure
- pkt_data  in  16  packet: 0_ppp×5 raw; 1_t[14:0] timestamp; 0x8000 wrap marker
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head when rec_valid & rec_ready
- rec_pixels  out  15  pattern, pixel0 in [14:12] ... pixel4 in [2:0]
- rec_time  out  45  local time of the pattern's first cycle
- rec_run  out  16  cycles the pattern was held, saturating at 0xFFFF
- err_ts  out  1  1-cycle pulse: timestamp disagreed with local time
- err_wrap  out  1  1-cycle pulse: wrap marker not at local low bits == 0
- overflow  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset (sync, rst=1 at posedge):
  - time_cnt = 2^45-LAT; state = IDLE; FIFO emptied; held pattern = 0.
  - All outputs 0: rec_valid, rec_pixels, rec_time, rec_run, err_ts, err_wrap, overflow.
  - Mid-operation reset discards the held run and any queued records. No record is emitted for the discarded run.
- time_cnt increments by 1 every cycle (mod 2^45). It equals the encoder timer value of the packet currently on pkt_data.
- Packet classification (pkt_valid=1):
  - bit15=0: raw.
  - 0x8000: wrap.
  - bit15=1 and low bits != 0: timestamp.
  - The encoder never sends timestamp value 0; a repeat starting at low==0 is signalled by the wrap marker alone.
- States: IDLE (no pattern yet), RAW, REPEAT.
  - IDLE + raw: hold pattern P, start = time_cnt, go to RAW. No record.
  - RAW/REPEAT + raw: push record {P, start, sat16(time_cnt - start)}, then load the new P and start = time_cnt, go to RAW.
  - RAW + timestamp: go to REPEAT.
  - REPEAT + timestamp: err_ts pulse; stay in REPEAT.
  - IDLE + timestamp: ignored; no error.
  - Wrap marker (any state): check and resync only. The state is unchanged. The slot counts as a repeat of P.
- Timestamp check: if t != time_cnt[14:0], pulse err_ts next cycle and load time_cnt[14:0] = t. Upper bits are unchanged.
- Wrap check: if time_cnt[14:0] != 0, pulse err_wrap next cycle and set low bits = 0.
  - Upper 30 bits +1 if the old low >= 0x4000 (marker early); otherwise unchanged (marker late).
  - A wrap at the correct time does nothing, because the counter carry already advanced the upper bits.
- Run length uses the pre-resync time_cnt.
- Record timing: pushed at the posedge that accepts the raw packet. rec_valid rises the following cycle if the FIFO was empty.
- FIFO behaviour:
  - Push and pop in the same cycle are both allowed when full.
  - A push while full with no pop drops the record and sets overflow, which holds until reset.
- Errors never block record generation.

Decomposition:
- Shared package row_pkt_pkg holds:
  - constants PKT_W=16, PIX_W=3, NPIX=5, TS_W=15, TIME_W=45, WRAP_MARK=16'h8000;
  - packet-kind enum {PK_RAW, PK_TS, PK_WRAP};
  - the record struct.
- One sub-module: row_rec_fifo (2-entry sync FIFO, valid/ready, full flag). All other logic stays in row_decoder_5p.

Test Plan:
- LAT=1, raw 0x1234 at local time 5, raw 0x0ABC at time 9 -> record {0x1234, 5, 4}; no errors.
- Raw 0x0111 at t=10, timestamp 0x800B at t=11, raw 0x0222 at t=20 -> record {0x0111, 10, 10}; err_ts=0.
- Timestamp 0x8010 at local low 0x000B -> err_ts pulse next cycle; time_cnt low becomes 0x0010; next record time reflects the resync.
- Wrap marker at local low 0x7FFE -> err_wrap pulse; upper bits +1, low 0. Wrap at low 0x0002 -> err_wrap; upper unchanged. Wrap at 0x0000 -> no error.
- rec_ready=0 with 3 records generated -> first 2 held in order, third dropped, overflow=1. Raising rec_ready drains 2 records; overflow stays 1.
- Run of 70000 cycles -> rec_run=0xFFFF. Reset asserted in REPEAT -> all outputs 0 next cycle; first record after reset uses the new pattern only.
